// File: rtl/ins_fetch_pkg.sv
// Shared CPU definitions used by the fetch unit: word widths, the JAL opcode,
// fetch FSM encoding and the instruction-queue entry layout.
package ins_fetch_pkg;

    localparam int INS_W = 32;
    localparam int PC_W  = 32;
    localparam int IQ_W  = INS_W + PC_W + 1;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [PC_W-1:0]  pc;
        logic             pred;
    } iq_entry_t;

    // J-type immediate, sign-extended to the PC width
    function automatic logic [PC_W-1:0] j_imm(input logic [INS_W-1:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ins_fetch_queue.sv
// Instruction queue for the fetch unit: circular buffer with a registered
// head copy so the decoder sees stable, flop-driven outputs.
module ins_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW-1:0]    wr_nxt, rd_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             pop_ok, push_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        rd_nxt   = rd_ptr + AW'(pop_ok);
        wr_nxt   = wr_ptr + AW'(push_ok);
        cnt_nxt  = cnt + CW'(push_ok) - CW'(pop_ok);
        head_nxt = '0;
        if (flush) begin
            rd_nxt  = '0;
            wr_nxt  = '0;
            cnt_nxt = '0;
        end
        // bypass the incoming word when it lands exactly at the new head
        if (!flush && cnt_nxt != '0) begin
            if (push_ok && wr_ptr == rd_nxt)
                head_nxt = din;
            else
                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
        end else begin
            if (push_ok && !flush)
                mem[wr_ptr] <= din;
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            cnt    <= cnt_nxt;
            dout   <= head_nxt;
        end
    end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: issues sequential fetch requests, tags in-order
// returns with their PC, discards stale returns after a redirect.
// Optional static JAL prediction is enabled by defining JAL_PREDICT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | requests may issue, returns are pushed into the queue
// ST_FLUSH | drop > 0: stale returns are discarded, no request issues
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_full,
    input  logic        ins_ready,
    input  logic [31:0] ins_value,
    input  logic        dec_ready,
    output logic [31:0] pc_addr,
    output logic        new_ins,
    output logic        dec_valid,
    output logic [31:0] dec_ins,
    output logic [31:0] dec_pc,
    output logic        dec_pred_taken
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_t    state;
    logic [PC_W-1:0] fetch_pc, ret_pc;
    logic [2:0]      outstanding, drop, drop_new;
    logic [4:0]      occupancy;

    logic [CW-1:0]   iq_count;
    logic            iq_full, iq_empty;
    iq_entry_t       iq_din, iq_dout;

    logic            keep_ret, drop_ret, issue, push, pop;
    logic            redir_any, push_pred;
    logic [PC_W-1:0] redir_pc;

    assign keep_ret = ins_ready && (drop == '0);
    assign drop_ret = ins_ready && (drop != '0);

`ifdef JAL_PREDICT_EN
    logic            jal_hit;
    logic [PC_W-1:0] jal_target;

    assign jal_hit    = keep_ret && (ins_value[6:0] == OPC_JAL);
    assign jal_target = ret_pc + j_imm(ins_value);
    // an external redirect wins over a same-cycle predicted JAL
    assign redir_any  = redirect_valid || jal_hit;
    assign redir_pc   = redirect_valid ? redirect_pc : jal_target;
    assign push_pred  = jal_hit;
`else
    assign redir_any  = redirect_valid;
    assign redir_pc   = redirect_pc;
    assign push_pred  = 1'b0;
`endif

    // the 3-bit outstanding counter also caps issue for deep queues
    assign occupancy = 5'(outstanding) + 5'(iq_count);
    assign issue     = (state == ST_RUN) && !if_full && !redir_any &&
                       (occupancy < 5'(IQ_DEPTH)) && (outstanding != 3'd7);

    assign push      = keep_ret && !redirect_valid;
    assign pop       = dec_valid && dec_ready && !redirect_valid;
    assign drop_new  = outstanding - 3'(ins_ready);

    assign iq_din    = '{ins: ins_value, pc: ret_pc, pred: push_pred};

    ins_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (IQ_W)
    ) u_iq (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .din   (iq_din),
        .pop   (pop),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_count),
        .dout  (iq_dout)
    );

    assign dec_valid      = !iq_empty;
    assign dec_ins        = iq_dout.ins;
    assign dec_pc         = iq_dout.pc;
    assign dec_pred_taken = iq_dout.pred;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            ret_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            new_ins     <= 1'b0;
            pc_addr     <= '0;
        end else begin
            new_ins     <= issue;
            if (issue)
                pc_addr <= fetch_pc;
            outstanding <= outstanding + 3'(issue) - 3'(ins_ready);

            if (redir_any) begin
                fetch_pc <= redir_pc;
                ret_pc   <= redir_pc;
                drop     <= drop_new;
                state    <= (drop_new != '0) ? ST_FLUSH : ST_RUN;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (keep_ret)
                    ret_pc <= ret_pc + 32'd4;
                if (drop_ret) begin
                    drop <= drop - 3'd1;
                    if (drop == 3'd1)
                        state <= ST_RUN;
                end
            end
        end
    end

    // iq_full is implied by the occupancy limit; kept for observability
    logic unused_full;
    assign unused_full = iq_full;

endmodule
